// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                 state;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   shreg_next;
  logic                   tick_end;
`ifdef UART_TX_PARITY_EN
  logic                   par_q;
`endif

  assign shreg_next = shreg >> 1;
  // Last oversample tick of the current bit: every bit boundary lands here.
  assign tick_end   = b_tick && (tick_cnt == TICK_LAST);

  // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE && b_tick)
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);

      case (state)
        IDLE: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_start) begin
            shreg    <= tx_data;
            tick_cnt <= '0;
            bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
            par_q    <= ^tx_data;
`endif
            state    <= START;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end

        START: begin
          if (tick_end) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end

        DATA: begin
          if (tick_end) begin
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par_q;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shreg   <= shreg_next;
              tx      <= shreg_next[0];
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
`endif

        STOP: begin
          if (tick_end) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
